// File: rtl/cdcm8_tx_modulator.sv
// Byte-to-CDCM-8 waveform modulator feeding the OSERDES TX stage, one word per clkDivIn.
// Define CDCM8_TX_PRBS_EN to add the prbsEn input and a PRBS7 test-pattern mode.
module cdcm8_tx_modulator #(
    parameter int kDevW     = 8,
    parameter int kTrainLen = 16
) (
    input  logic             clkDivIn,
    input  logic             ioReset,
    input  logic [7:0]       dataIn,
    input  logic             validIn,
`ifdef CDCM8_TX_PRBS_EN
    input  logic             prbsEn,
`endif
    output logic             readyOut,
    output logic [kDevW-1:0] dOutToDevice,
    output logic             trainDone
);

    localparam logic [kDevW-1:0] kIdle  = kDevW'(8'hF0);
    localparam logic [kDevW-1:0] kStart = kDevW'(8'hFC);
    localparam logic [kDevW-1:0] kBit1  = kDevW'(8'hF8);
    localparam logic [kDevW-1:0] kBit0  = kDevW'(8'hE0);
    localparam logic [7:0]       kTrainLast = 8'(kTrainLen - 1);

    typedef enum logic [2:0] {
        TRAIN,
        IDLE,
        START,
`ifdef CDCM8_TX_PRBS_EN
        PRBS,
`endif
        SEND
    } state_t;

    state_t     state;
    logic [7:0] trainCnt;
    logic [2:0] bitCnt;
    logic [7:0] shreg;
    logic       accept;
`ifdef CDCM8_TX_PRBS_EN
    logic [6:0] lfsr;
`endif

    assign accept = validIn && readyOut;

    // dOutToDevice carries the word for the state being left at each edge,
    // so a byte accepted at edge N shows START after edge N+1.
    always_ff @(posedge clkDivIn or posedge ioReset) begin
        if (ioReset) begin
            state        <= TRAIN;
            dOutToDevice <= kIdle;
            readyOut     <= 1'b0;
            trainDone    <= 1'b0;
            trainCnt     <= '0;
            bitCnt       <= '0;
            shreg        <= '0;
`ifdef CDCM8_TX_PRBS_EN
            lfsr         <= 7'h7F;
`endif
        end else begin
            case (state)
                TRAIN: begin
                    dOutToDevice <= kIdle;
                    if (trainCnt == kTrainLast) begin
                        state     <= IDLE;
                        trainDone <= 1'b1;
                        readyOut  <= 1'b1;
                    end else begin
                        trainCnt <= trainCnt + 8'd1;
                    end
                end
                IDLE: begin
                    dOutToDevice <= kIdle;
                    if (accept) begin
                        shreg    <= dataIn;
                        state    <= START;
                        readyOut <= 1'b0;
                    end
`ifdef CDCM8_TX_PRBS_EN
                    else if (prbsEn) begin
                        state    <= PRBS;
                        readyOut <= 1'b0;
                    end
`endif
                end
                START: begin
                    dOutToDevice <= kStart;
                    bitCnt       <= '0;
                    state        <= SEND;
                    readyOut     <= 1'b0;
                end
                SEND: begin
                    dOutToDevice <= shreg[7] ? kBit1 : kBit0;
                    shreg        <= {shreg[6:0], 1'b0};
                    bitCnt       <= bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        // Last bit: a chained byte goes straight to START, no IDLE gap.
                        if (accept) begin
                            shreg    <= dataIn;
                            state    <= START;
                            readyOut <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            readyOut <= 1'b1;
                        end
                    end else begin
                        readyOut <= (bitCnt == 3'd6);
                    end
                end
`ifdef CDCM8_TX_PRBS_EN
                PRBS: begin
                    if (prbsEn) begin
                        dOutToDevice <= lfsr[6] ? kBit1 : kBit0;
                        lfsr         <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
                    end else begin
                        dOutToDevice <= kIdle;
                        state        <= IDLE;
                        readyOut     <= 1'b1;
                    end
                end
`endif
                default: begin
                    state        <= TRAIN;
                    dOutToDevice <= kIdle;
                    readyOut     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdcm8_tx_modulator.sv
// Directed vector bench for cdcm8_tx_modulator: training, framing, streaming, reset, PRBS.
// Define CDCM8_TX_PRBS_EN to also exercise the PRBS7 mode.
module tb_cdcm8_tx_modulator;

    logic       clkDivIn = 1'b0;
    logic       ioReset;
    logic [7:0] dataIn;
    logic       validIn;
    logic       readyOut;
    logic [7:0] dOutToDevice;
    logic       trainDone;
`ifdef CDCM8_TX_PRBS_EN
    logic       prbsEn = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [7:0] eo;
        logic       er;
        logic       et;
        string      tag;
    } vec_t;

    vec_t vq[$];

    always #5 clkDivIn = ~clkDivIn;

    cdcm8_tx_modulator #(.kDevW(8), .kTrainLen(16)) dut (
        .clkDivIn    (clkDivIn),
        .ioReset     (ioReset),
        .dataIn      (dataIn),
        .validIn     (validIn),
`ifdef CDCM8_TX_PRBS_EN
        .prbsEn      (prbsEn),
`endif
        .readyOut    (readyOut),
        .dOutToDevice(dOutToDevice),
        .trainDone   (trainDone)
    );

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkAll(input string nm, input logic [7:0] eo,
                          input logic er, input logic et);
        chk({nm, ".dOut"}, dOutToDevice, eo);
        chk({nm, ".ready"}, {7'd0, readyOut}, {7'd0, er});
        chk({nm, ".trainDone"}, {7'd0, trainDone}, {7'd0, et});
    endtask

    function automatic void add(input logic v, input logic [7:0] d,
                                input logic [7:0] eo, input logic er,
                                input logic et, input string tag);
        vec_t x;
        x.v = v; x.d = d; x.eo = eo; x.er = er; x.et = et; x.tag = tag;
        vq.push_back(x);
    endfunction

    // One frame from IDLE (or chained off a previous frame's last bit).
    function automatic void addFrame(input logic [7:0] b, input bit chained,
                                     input logic vDur, input logic [7:0] dDur,
                                     input string tag);
        logic [7:0] w;
        if (!chained) add(1'b1, b, 8'hF0, 1'b0, 1'b1, {tag, ".acc"});
        add(vDur, dDur, 8'hFC, 1'b0, 1'b1, {tag, ".start"});
        for (int k = 0; k < 8; k++) begin
            w = b[7-k] ? 8'hF8 : 8'hE0;
            add(vDur, dDur, w, (k == 6) || (k == 7 && !vDur), 1'b1,
                $sformatf("%s.bit%0d", tag, k));
        end
    endfunction

    task automatic runVecs();
        foreach (vq[i]) begin
            validIn = vq[i].v;
            dataIn  = vq[i].d;
            @(posedge clkDivIn);
            #1;
            chkAll(vq[i].tag, vq[i].eo, vq[i].er, vq[i].et);
        end
        vq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ioReset = 1'b1;
        validIn = 1'b1;
        dataIn  = 8'h55;
        repeat (2) @(posedge clkDivIn);
        #1;
        chkAll("reset", 8'hF0, 1'b0, 1'b0);
        ioReset = 1'b0;

        // Training with a byte offered throughout; it is taken when ready rises.
        for (int i = 1; i <= 16; i++)
            add(1'b1, 8'h55, 8'hF0, i == 16, i == 16, $sformatf("train%0d", i));
        addFrame(8'h55, 1'b0, 1'b0, 8'h00, "b55");
        add(1'b0, 8'h00, 8'hF0, 1'b1, 1'b1, "b55.idle");
        add(1'b0, 8'h00, 8'hF0, 1'b1, 1'b1, "idle");
        addFrame(8'hA5, 1'b0, 1'b0, 8'h00, "bA5");
        add(1'b0, 8'h00, 8'hF0, 1'b1, 1'b1, "bA5.idle");
        addFrame(8'hFF, 1'b0, 1'b1, 8'h00, "bFF");
        addFrame(8'h00, 1'b1, 1'b0, 8'h00, "b00");
        add(1'b0, 8'h00, 8'hF0, 1'b1, 1'b1, "b00.idle");
        runVecs();

        // Reset while the 4th data bit of 8'h3C is on the line.
        add(1'b1, 8'h3C, 8'hF0, 1'b0, 1'b1, "b3C.acc");
        add(1'b0, 8'h00, 8'hFC, 1'b0, 1'b1, "b3C.start");
        add(1'b0, 8'h00, 8'hE0, 1'b0, 1'b1, "b3C.bit0");
        add(1'b0, 8'h00, 8'hE0, 1'b0, 1'b1, "b3C.bit1");
        add(1'b0, 8'h00, 8'hF8, 1'b0, 1'b1, "b3C.bit2");
        add(1'b0, 8'h00, 8'hF8, 1'b0, 1'b1, "b3C.bit3");
        runVecs();
        ioReset = 1'b1;
        #1;
        chkAll("midReset.async", 8'hF0, 1'b0, 1'b0);
        @(posedge clkDivIn);
        #1;
        chkAll("midReset.held", 8'hF0, 1'b0, 1'b0);
        ioReset = 1'b0;
        for (int i = 1; i <= 16; i++)
            add(1'b0, 8'h00, 8'hF0, i == 16, i == 16, $sformatf("retrain%0d", i));
        for (int i = 0; i < 3; i++)
            add(1'b0, 8'h00, 8'hF0, 1'b1, 1'b1, $sformatf("postIdle%0d", i));
        runVecs();

`ifdef CDCM8_TX_PRBS_EN
        validIn = 1'b0;
        prbsEn  = 1'b1;
        @(posedge clkDivIn);
        #1;
        chkAll("prbs.enter", 8'hF0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clkDivIn);
            #1;
            chkAll($sformatf("prbs%0d", i), (i < 7) ? 8'hF8 : 8'hE0, 1'b0, 1'b1);
        end
        prbsEn = 1'b0;
        @(posedge clkDivIn);
        #1;
        chkAll("prbs.exit", 8'hF0, 1'b1, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
